fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipeline, directly upstream of the PC adder. Each fetch it takes the adder's `nextPC`, requests the instruction word from instruction memory with a req/ack handshake, and registers the word and its address as `instructionOut` / `currentPCOut` for the adder and decoder. Memory wait states and downstream stalls are absorbed by a one-word hold buffer; a flush turns the outgoing word into a NOP.

## Interface
Parameters:
- `NOP_WORD`, default 16'h0800: word issued on reset and flush.
- `RESET_PC`, default 16'hfffe: reset value of `currentPCOut`, so the adder produces first fetch address 0x0000.

Ports:
- `clk`  in  1  — the single clock; all state updates on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `nextPC`  in  16  — next fetch address from the PC adder.
- `stall`  in  1  — hazard unit: hold outputs, do not deliver.
- `flush`  in  1  — discard the in-flight or held word.
- `imemReq`  out  1  — fetch request.
- `imemAddr`  out  16  — fetch address, stable while `imemReq`=1.
- `imemAck`  in  1  — memory has `imemData` valid this cycle.
- `imemData`  in  16  — fetched word.
- `instructionOut`  out  16  — registered instruction to the PC adder and decoder.
- `currentPCOut`  out  16  — address of `instructionOut`.
- `fetchValid`  out  1  — one-cycle pulse: new valid word delivered.
- `alignFault`  out  1  — sticky misaligned-fetch flag (see Configuration).

## Operation
- State machine with three states: ISSUE, WAIT, HELD.
- ISSUE: `imemReq`=0.
  - `stall`=0: latch `fetchPC`<=`nextPC`, go to WAIT.
  - `stall`=1: stay in ISSUE.
- WAIT: `imemReq`=1, `imemAddr`=`fetchPC`.
  - No ack: stay in WAIT. If `flush`=1 this cycle, set `flushPend`.
  - Ack with `stall`=0: `instructionOut`<=(`flush`|`flushPend`) ? `NOP_WORD` : `imemData`, `currentPCOut`<=`fetchPC`, `fetchValid`<=!(`flush`|`flushPend`). Clear `flushPend`, go to ISSUE.
  - Ack with `stall`=1: `holdBuf`<=`imemData`, `flushPend`|=`flush`, go to HELD.
- HELD: `imemReq`=0; outputs unchanged.
  - `flush` sets `flushPend`.
  - When `stall`=0: deliver `holdBuf` (or NOP if `flushPend`|`flush`) exactly as in the WAIT ack case, then go to ISSUE.
- `fetchValid` is 0 in every cycle that does not follow a delivery.
- `imemAddr` is a register equal to `fetchPC`; it changes only on the ISSUE->WAIT edge.
- Arithmetic: none. `nextPC` is used unmodified, 16 bits, with no wrap handling required (0xfffe+2 = 0x0000 is computed by the adder).

## Timing
- Reset values: state=ISSUE, `imemReq`=0, `imemAddr`=0x0000, `fetchPC`=0x0000, `instructionOut`=`NOP_WORD`, `currentPCOut`=`RESET_PC`, `fetchValid`=0, `alignFault`=0, `flushPend`=0, `holdBuf`=0.
- Minimum throughput is one instruction every 2 cycles: ISSUE cycle, then WAIT cycle with same-cycle ack. New outputs are visible after the rising edge ending WAIT.
- Each extra memory wait state adds one cycle; `imemReq` and `imemAddr` are held constant throughout.
- `nextPC` is sampled only in ISSUE, one cycle after delivery, so it always reflects the newly registered `instructionOut` / `currentPCOut`.
- Simultaneous `flush` and ack: flush wins and NOP is delivered.
- Simultaneous `stall` and `flush` in HELD: word is marked flushed and stays held.
- Reset asserted mid-WAIT: `imemReq` drops asynchronously and any late ack is ignored.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In ISSUE, if `nextPC[0]`=1, no request is issued.
  - `alignFault` is set (sticky until `rst`), and the FSM remains in ISSUE with `imemReq`=0.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `fetchPC`<={`nextPC[15:1]`,1'b0}.
  - `alignFault` is tied 0.

## Test plan
- Release reset, ack same cycle as req, adder model nextPC=currentPCOut+2 -> imemAddr sequence 0x0000, 0x0002, 0x0004; fetchValid pulses every 2nd cycle; currentPCOut matches.
- Ack delayed 3 cycles, imemData=0x4A05 -> imemReq high 3 cycles with imemAddr stable; instructionOut=0x4A05 one edge after ack.
- stall=1 when ack arrives with 0x1234 -> imemReq=0, outputs unchanged for 4 stall cycles; stall drops -> instructionOut=0x1234, fetchValid=1 next edge.
- flush pulse in WAIT before ack -> instructionOut=0x0800, fetchValid=0, currentPCOut=fetchPC; next fetch proceeds normally.
- rst asserted mid-WAIT -> imemReq=0 immediately, instructionOut=0x0800, currentPCOut=0xfffe; after release first imemAddr=0x0000.
- With FETCH_ALIGN_CHECK_EN, nextPC=0x0003 -> alignFault=1, no request until reset. Without it, imemAddr=0x0002.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: req/ack fetch from imem with a one-word hold buffer and flush-to-NOP.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [15:0] NOP_WORD = 16'h0800,
    parameter logic [15:0] RESET_PC = 16'hfffe
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nextPC,
    input  logic        stall,
    input  logic        flush,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic        imemAck,
    input  logic [15:0] imemData,
    output logic [15:0] instructionOut,
    output logic [15:0] currentPCOut,
    output logic        fetchValid,
    output logic        alignFault
);

    typedef enum logic [1:0] {ISSUE, WAIT, HELD} state_t;

    state_t      state;
    logic [15:0] fetchPC;
    logic [15:0] holdBuf;
    logic        flushPend;

    logic [15:0] issueAddr;
    logic        issueGo;
    logic        deliverGo;
    logic        kill;
    logic [15:0] deliverData;

    // Misaligned address either traps (checked build) or is forced even.
`ifdef FETCH_ALIGN_CHECK_EN
    logic alignFaultQ;
    assign issueAddr  = nextPC;
    assign issueGo    = !stall && !nextPC[0] && !alignFaultQ;
    assign alignFault = alignFaultQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alignFaultQ <= 1'b0;
        end else if (state == ISSUE && !stall && nextPC[0]) begin
            alignFaultQ <= 1'b1;
        end
    end
`else
    assign issueAddr  = nextPC & 16'hfffe;
    assign issueGo    = !stall;
    assign alignFault = 1'b0;
`endif

    assign deliverGo   = !stall && ((state == WAIT && imemAck) || state == HELD);
    assign kill        = flush || flushPend;
    assign deliverData = (state == HELD) ? holdBuf : imemData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ISSUE;
            imemReq        <= 1'b0;
            imemAddr       <= 16'h0000;
            fetchPC        <= 16'h0000;
            instructionOut <= NOP_WORD;
            currentPCOut   <= RESET_PC;
            fetchValid     <= 1'b0;
            flushPend      <= 1'b0;
            holdBuf        <= 16'h0000;
        end else begin
            fetchValid <= 1'b0;
            if (deliverGo) begin
                instructionOut <= kill ? NOP_WORD : deliverData;
                currentPCOut   <= fetchPC;
                fetchValid     <= !kill;
                flushPend      <= 1'b0;
                imemReq        <= 1'b0;
                state          <= ISSUE;
            end else begin
                case (state)
                    ISSUE: begin
                        if (issueGo) begin
                            fetchPC  <= issueAddr;
                            imemAddr <= issueAddr;
                            imemReq  <= 1'b1;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        // Ack under stall parks the word; the flush mark travels with it.
                        if (imemAck) begin
                            holdBuf <= imemData;
                            imemReq <= 1'b0;
                            state   <= HELD;
                        end
                        if (flush) flushPend <= 1'b1;
                    end
                    HELD: begin
                        if (flush) flushPend <= 1'b1;
                    end
                    default: state <= ISSUE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory and PC adder are modelled here.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nextPC;
    logic        stall;
    logic        flush;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [15:0] imemData;
    logic [15:0] instructionOut;
    logic [15:0] currentPCOut;
    logic        fetchValid;
    logic        alignFault;

    logic        autoAck;
    logic        manAck;
    logic [15:0] manData;
    logic        useModel;
    logic [15:0] forcedPC;

    int total = 0;
    int bad   = 0;

    logic [49:0] obs;
    logic [49:0] exp;

    always #5 clk = ~clk;

    assign nextPC   = useModel ? 16'(currentPCOut + 16'd2) : forcedPC;
    assign imemAck  = autoAck ? imemReq : manAck;
    assign imemData = autoAck ? {8'h10, imemAddr[7:0]} : manData;
    assign obs      = {imemReq, imemAddr, fetchValid, instructionOut, currentPCOut};

    fetch_stage dut (
        .clk(clk), .rst(rst), .nextPC(nextPC), .stall(stall), .flush(flush),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .instructionOut(instructionOut), .currentPCOut(currentPCOut),
        .fetchValid(fetchValid), .alignFault(alignFault)
    );

    // obs fields: {req, addr, fetchValid, instr, pc}
    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; flush = 1'b0; autoAck = 1'b0; manAck = 1'b0;
        manData = 16'h0000; useModel = 1'b1; forcedPC = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        exp = {1'b0, 16'h0000, 1'b0, 16'h0800, 16'hfffe};
        total++; if (obs !== exp) begin bad++; $display("FAIL reset_state: got %h want %h", obs, exp); end
        total++; if (alignFault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", alignFault); end
    endtask

    task automatic test_basic();
        rst = 1'b0; stall = 1'b0; autoAck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = (i == 0) ? {1'b1, 16'h0000, 1'b0, 16'h0800, 16'hfffe}
                           : {1'b1, 16'(2 * i), 1'b0, 16'(16'h1000 + 2 * (i - 1)), 16'(2 * (i - 1))};
            total++; if (obs !== exp) begin bad++; $display("FAIL basic_req%0d: got %h want %h", i, obs, exp); end
            @(negedge clk);
            exp = {1'b0, 16'(2 * i), 1'b1, 16'(16'h1000 + 2 * i), 16'(2 * i)};
            total++; if (obs !== exp) begin bad++; $display("FAIL basic_dlv%0d: got %h want %h", i, obs, exp); end
        end
        stall = 1'b1; autoAck = 1'b0;
    endtask

    task automatic test_wait_states();
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = {1'b1, 16'h0006, 1'b0, 16'h1004, 16'h0004};
            total++; if (obs !== exp) begin bad++; $display("FAIL wait_hold%0d: got %h want %h", k, obs, exp); end
        end
        manAck = 1'b1; manData = 16'h4a05;
        @(negedge clk);
        manAck = 1'b0;
        exp = {1'b0, 16'h0006, 1'b1, 16'h4a05, 16'h0006};
        total++; if (obs !== exp) begin bad++; $display("FAIL wait_dlv: got %h want %h", obs, exp); end
        stall = 1'b1;
    endtask

    task automatic test_stall_held();
        stall = 1'b0;
        @(negedge clk);
        exp = {1'b1, 16'h0008, 1'b0, 16'h4a05, 16'h0006};
        total++; if (obs !== exp) begin bad++; $display("FAIL held_req: got %h want %h", obs, exp); end
        manAck = 1'b1; manData = 16'h1234; stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            manAck = 1'b0;
            exp = {1'b0, 16'h0008, 1'b0, 16'h4a05, 16'h0006};
            total++; if (obs !== exp) begin bad++; $display("FAIL held_stall%0d: got %h want %h", k, obs, exp); end
        end
        stall = 1'b0;
        @(negedge clk);
        exp = {1'b0, 16'h0008, 1'b1, 16'h1234, 16'h0008};
        total++; if (obs !== exp) begin bad++; $display("FAIL held_dlv: got %h want %h", obs, exp); end
        stall = 1'b1;
    endtask

    task automatic test_flush_wait();
        stall = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        exp = {1'b1, 16'h000a, 1'b0, 16'h1234, 16'h0008};
        total++; if (obs !== exp) begin bad++; $display("FAIL flush_req: got %h want %h", obs, exp); end
        @(negedge clk);
        flush = 1'b0; manAck = 1'b1; manData = 16'hbeef;
        total++; if (obs !== exp) begin bad++; $display("FAIL flush_wait: got %h want %h", obs, exp); end
        @(negedge clk);
        manAck = 1'b0;
        exp = {1'b0, 16'h000a, 1'b0, 16'h0800, 16'h000a};
        total++; if (obs !== exp) begin bad++; $display("FAIL flush_nop: got %h want %h", obs, exp); end
        @(negedge clk);
        exp = {1'b1, 16'h000c, 1'b0, 16'h0800, 16'h000a};
        total++; if (obs !== exp) begin bad++; $display("FAIL flush_next_req: got %h want %h", obs, exp); end
        manAck = 1'b1; manData = 16'h2222;
        @(negedge clk);
        manAck = 1'b0;
        exp = {1'b0, 16'h000c, 1'b1, 16'h2222, 16'h000c};
        total++; if (obs !== exp) begin bad++; $display("FAIL flush_next_dlv: got %h want %h", obs, exp); end
        stall = 1'b1;
    endtask

    task automatic test_flush_held();
        stall = 1'b0;
        @(negedge clk);
        exp = {1'b1, 16'h000e, 1'b0, 16'h2222, 16'h000c};
        total++; if (obs !== exp) begin bad++; $display("FAIL fheld_req: got %h want %h", obs, exp); end
        manAck = 1'b1; manData = 16'h3333; stall = 1'b1;
        @(negedge clk);
        manAck = 1'b0; flush = 1'b1;
        exp = {1'b0, 16'h000e, 1'b0, 16'h2222, 16'h000c};
        total++; if (obs !== exp) begin bad++; $display("FAIL fheld_park: got %h want %h", obs, exp); end
        @(negedge clk);
        flush = 1'b0;
        total++; if (obs !== exp) begin bad++; $display("FAIL fheld_stay: got %h want %h", obs, exp); end
        stall = 1'b0;
        @(negedge clk);
        exp = {1'b0, 16'h000e, 1'b0, 16'h0800, 16'h000e};
        total++; if (obs !== exp) begin bad++; $display("FAIL fheld_nop: got %h want %h", obs, exp); end
        stall = 1'b1;
    endtask

    task automatic test_flush_ack();
        stall = 1'b0;
        @(negedge clk);
        exp = {1'b1, 16'h0010, 1'b0, 16'h0800, 16'h000e};
        total++; if (obs !== exp) begin bad++; $display("FAIL fack_req: got %h want %h", obs, exp); end
        flush = 1'b1; manAck = 1'b1; manData = 16'h9999;
        @(negedge clk);
        flush = 1'b0; manAck = 1'b0;
        exp = {1'b0, 16'h0010, 1'b0, 16'h0800, 16'h0010};
        total++; if (obs !== exp) begin bad++; $display("FAIL fack_nop: got %h want %h", obs, exp); end
        stall = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        stall = 1'b0;
        @(negedge clk);
        exp = {1'b1, 16'h0012, 1'b0, 16'h0800, 16'h0010};
        total++; if (obs !== exp) begin bad++; $display("FAIL rmid_req: got %h want %h", obs, exp); end
        #2 rst = 1'b1; manAck = 1'b1; manData = 16'h5555;
        #1;
        exp = {1'b0, 16'h0000, 1'b0, 16'h0800, 16'hfffe};
        total++; if (obs !== exp) begin bad++; $display("FAIL rmid_async: got %h want %h", obs, exp); end
        @(negedge clk);
        manAck = 1'b0;
        total++; if (obs !== exp) begin bad++; $display("FAIL rmid_late_ack: got %h want %h", obs, exp); end
        rst = 1'b0;
        @(negedge clk);
        exp = {1'b1, 16'h0000, 1'b0, 16'h0800, 16'hfffe};
        total++; if (obs !== exp) begin bad++; $display("FAIL rmid_restart: got %h want %h", obs, exp); end
        manAck = 1'b1; manData = 16'h6666;
        @(negedge clk);
        manAck = 1'b0;
        exp = {1'b0, 16'h0000, 1'b1, 16'h6666, 16'h0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL rmid_dlv: got %h want %h", obs, exp); end
        stall = 1'b1;
    endtask

    task automatic test_misalign();
        useModel = 1'b0; forcedPC = 16'h0003; stall = 1'b0;
        @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        exp = {1'b0, 16'h0000, 1'b0, 16'h6666, 16'h0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL malign_noreq: got %h want %h", obs, exp); end
        total++; if (alignFault !== 1'b1) begin bad++; $display("FAIL malign_fault: got %b want 1", alignFault); end
        forcedPC = 16'h0004;
        @(negedge clk);
        total++; if (obs !== exp) begin bad++; $display("FAIL malign_locked: got %h want %h", obs, exp); end
        total++; if (alignFault !== 1'b1) begin bad++; $display("FAIL malign_sticky: got %b want 1", alignFault); end
`else
        exp = {1'b1, 16'h0002, 1'b0, 16'h6666, 16'h0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL malign_req: got %h want %h", obs, exp); end
        total++; if (alignFault !== 1'b0) begin bad++; $display("FAIL malign_fault: got %b want 0", alignFault); end
        manAck = 1'b1; manData = 16'h7777;
        @(negedge clk);
        manAck = 1'b0;
        exp = {1'b0, 16'h0002, 1'b1, 16'h7777, 16'h0002};
        total++; if (obs !== exp) begin bad++; $display("FAIL malign_dlv: got %h want %h", obs, exp); end
`endif
        stall = 1'b1; useModel = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_stall_held();
        test_flush_wait();
        test_flush_held();
        test_flush_ack();
        test_reset_mid_wait();
        test_misalign();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
